// File: rtl/fwrisc_regfile_pkg.sv
// Shared types and helpers for the fwrisc multi-port register file.
// The parity option is enabled by defining FWRISC_REGFILE_PARITY_EN.
package fwrisc_regfile_pkg;

  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_ADDR_W = 6;

  // Widest entry the parity helper accepts; narrower data is zero-extended.
  localparam int RF_PAR_MAX_W  = 64;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // Even parity bit: data plus this bit always holds an even number of ones.
  function automatic logic rf_even_par(input logic [RF_PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fwrisc_regfile_mp_if.sv
// Read/write port bundle between decode/writeback and the register file.
// Parity signals exist only when FWRISC_REGFILE_PARITY_EN is defined.
interface fwrisc_regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int N_RD   = 2
);

  // There is no per-transfer valid/ready pair: rf_ready is a level gate.
  // While it is low, writes are ignored and all read data is zero; once high
  // it stays high until reset, and every write/read is accepted on each edge.
  logic [N_RD*ADDR_W-1:0] rd_raddr;
  logic [N_RD*DATA_W-1:0] rd_rdata;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_en;
  logic                   rf_ready;
`ifdef FWRISC_REGFILE_PARITY_EN
  logic                   wr_par_inj;
  logic [N_RD-1:0]        rd_perr;
`endif

  modport master (
    output rd_raddr,
    output wr_addr,
    output wr_data,
    output wr_en,
`ifdef FWRISC_REGFILE_PARITY_EN
    output wr_par_inj,
    input  rd_perr,
`endif
    input  rd_rdata,
    input  rf_ready
  );

  modport slave (
    input  rd_raddr,
    input  wr_addr,
    input  wr_data,
    input  wr_en,
`ifdef FWRISC_REGFILE_PARITY_EN
    input  wr_par_inj,
    output rd_perr,
`endif
    output rd_rdata,
    output rf_ready
  );

endinterface

// File: rtl/fwrisc_regfile_rdport.sv
// One registered read port with write bypass and hardwired-zero handling.
// Parity error reporting is present when FWRISC_REGFILE_PARITY_EN is defined.
module fwrisc_regfile_rdport
  import fwrisc_regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DEF_DATA_W,
  parameter int ADDR_W  = RF_DEF_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  rf_state_e         state,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] ent_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef FWRISC_REGFILE_PARITY_EN
  input  logic              ent_perr,
  output logic              perr,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              zero_hit;
  logic              byp_hit;
`ifdef FWRISC_REGFILE_PARITY_EN
  logic              perr_d, perr_q;
`endif

  // Zero check wins over bypass so a dropped write to entry 0 never leaks.
  always_comb begin
    zero_hit = (ZERO_R0 != 0) && (raddr == '0);
    byp_hit  = (state == READY) && wr_en && (wr_addr == raddr);
    rdata_d  = '0;
`ifdef FWRISC_REGFILE_PARITY_EN
    perr_d   = 1'b0;
`endif
    if ((state == READY) && !zero_hit) begin
      if (byp_hit) begin
        rdata_d = wr_data;
      end else begin
        rdata_d = ent_data;
`ifdef FWRISC_REGFILE_PARITY_EN
        perr_d  = ent_perr;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
`ifdef FWRISC_REGFILE_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      rdata_q <= rdata_d;
`ifdef FWRISC_REGFILE_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign rdata = rdata_q;
`ifdef FWRISC_REGFILE_PARITY_EN
  assign perr  = perr_q;
`endif

endmodule

// File: rtl/fwrisc_regfile_mp.sv
// Parametrised multi-read-port register file with a post-reset clearing
// sequencer. Define FWRISC_REGFILE_PARITY_EN to store a parity bit per entry.
module fwrisc_regfile_mp
  import fwrisc_regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DEF_DATA_W,
  parameter int ADDR_W  = RF_DEF_ADDR_W,
  parameter int N_RD    = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                clock,
  input  logic                reset,
  fwrisc_regfile_mp_if.slave  rf,
  output rf_state_e           dbg_state
);

  localparam int DEPTH = 2**ADDR_W;
`ifdef FWRISC_REGFILE_PARITY_EN
  localparam int ENT_W = DATA_W + 1;
`else
  localparam int ENT_W = DATA_W;
`endif

  rf_state_e         state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic              ready_d, ready_q;

  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ENT_W-1:0]  went;

  // The sequencer owns the write port in INIT; the user port only in READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    we      = 1'b0;
    waddr   = rf.wr_addr;
    wdata   = rf.wr_data;
    case (state_q)
      INIT: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY: begin
        we = rf.wr_en && !((ZERO_R0 != 0) && (rf.wr_addr == '0));
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
    if (reset) begin
      we = 1'b0;
    end
  end

`ifdef FWRISC_REGFILE_PARITY_EN
  // Injection only applies to user writes; cleared entries carry good parity.
  assign went = {rf_even_par(RF_PAR_MAX_W'(wdata)) ^ ((state_q == READY) && rf.wr_par_inj),
                 wdata};
`else
  assign went = wdata;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = went;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately not reset; the sequencer clears it instead.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  logic [N_RD-1:0][DATA_W-1:0] rdata_all;
`ifdef FWRISC_REGFILE_PARITY_EN
  logic [N_RD-1:0]             perr_all;
`endif

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [ENT_W-1:0]  ent;
    assign raddr = rf.rd_raddr[g*ADDR_W +: ADDR_W];
    assign ent   = mem_q[raddr];
`ifdef FWRISC_REGFILE_PARITY_EN
    logic ent_perr;
    assign ent_perr = ent[DATA_W] ^ rf_even_par(RF_PAR_MAX_W'(ent[DATA_W-1:0]));
`endif

    fwrisc_regfile_rdport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
    ) u_rdport (
      .clock    (clock),
      .reset    (reset),
      .state    (state_q),
      .raddr    (raddr),
      .ent_data (ent[DATA_W-1:0]),
      .wr_en    (rf.wr_en),
      .wr_addr  (rf.wr_addr),
      .wr_data  (rf.wr_data),
`ifdef FWRISC_REGFILE_PARITY_EN
      .ent_perr (ent_perr),
      .perr     (perr_all[g]),
`endif
      .rdata    (rdata_all[g])
    );
  end

  assign rf.rd_rdata = rdata_all;
`ifdef FWRISC_REGFILE_PARITY_EN
  assign rf.rd_perr  = perr_all;
`endif
  assign rf.rf_ready = ready_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fwrisc_regfile_mp.sv
// Bench for fwrisc_regfile_mp: a ZERO_R0=1 and a ZERO_R0=0 instance share
// stimulus and are checked every cycle against an array-based model.
module tb_fwrisc_regfile_mp;
  import fwrisc_regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int NR    = 2;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] ra0, ra1, wa;
  logic [DW-1:0] wd;
  logic          we;
  logic          inj;

  fwrisc_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) ifz ();
  fwrisc_regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR)) ifn ();

  assign ifz.rd_raddr = {ra1, ra0};
  assign ifz.wr_addr  = wa;
  assign ifz.wr_data  = wd;
  assign ifz.wr_en    = we;
  assign ifn.rd_raddr = {ra1, ra0};
  assign ifn.wr_addr  = wa;
  assign ifn.wr_data  = wd;
  assign ifn.wr_en    = we;
`ifdef FWRISC_REGFILE_PARITY_EN
  assign ifz.wr_par_inj = inj;
  assign ifn.wr_par_inj = inj;
`endif

  rf_state_e st_z, st_n;

  fwrisc_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(1)) dut_z (
    .clock     (clk),
    .reset     (rst),
    .rf        (ifz.slave),
    .dbg_state (st_z)
  );

  fwrisc_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(0)) dut_n (
    .clock     (clk),
    .reset     (rst),
    .rf        (ifn.slave),
    .dbg_state (st_n)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [NR*DW-1:0] exp_z_q[$];
  logic [NR*DW-1:0] exp_n_q[$];
  logic [NR-1:0]    exp_pz_q[$];
  logic [NR-1:0]    exp_pn_q[$];
  logic             exp_ready;

  // Model: edges since reset release, plus one array per zero-register flavour.
  int            init_cnt;
  logic [DW-1:0] mz [DEPTH];
  logic [DW-1:0] mn [DEPTH];
  logic          bz [DEPTH];
  logic          bn [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming clock edge from the current inputs.
  task automatic model_edge();
    logic [AW-1:0]    a [NR];
    logic [NR*DW-1:0] ez, en;
    logic [NR-1:0]    pz, pn;
    a[0] = ra0;
    a[1] = ra1;
    ez = '0;
    en = '0;
    pz = '0;
    pn = '0;
    if (rst) begin
      init_cnt  = 0;
      exp_ready = 1'b0;
    end else if (init_cnt < DEPTH) begin
      init_cnt++;
      if (init_cnt == DEPTH) begin
        exp_ready = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
          mz[e] = '0;
          mn[e] = '0;
          bz[e] = 1'b0;
          bn[e] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (a[i] != 0) begin
          if (we && wa == a[i]) begin
            ez[i*DW +: DW] = wd;
          end else begin
            ez[i*DW +: DW] = mz[a[i]];
            pz[i] = bz[a[i]];
          end
        end
        if (we && wa == a[i]) begin
          en[i*DW +: DW] = wd;
        end else begin
          en[i*DW +: DW] = mn[a[i]];
          pn[i] = bn[a[i]];
        end
      end
      if (we) begin
        if (wa != 0) begin
          mz[wa] = wd;
          bz[wa] = inj;
        end
        mn[wa] = wd;
        bn[wa] = inj;
      end
    end
    exp_z_q.push_back(ez);
    exp_n_q.push_back(en);
    exp_pz_q.push_back(pz);
    exp_pn_q.push_back(pn);
  endtask

  task automatic compare_outputs();
    logic [NR*DW-1:0] ez, en;
    logic [NR-1:0]    pz, pn;
    if (exp_z_q.size() == 0 || exp_n_q.size() == 0 ||
        exp_pz_q.size() == 0 || exp_pn_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL exp_queue: got empty expected queue at %0t", $time);
    end else begin
      ez = exp_z_q.pop_front();
      en = exp_n_q.pop_front();
      pz = exp_pz_q.pop_front();
      pn = exp_pn_q.pop_front();
      check("rdata_z", ifz.rd_rdata, ez);
      check("rdata_n", ifn.rd_rdata, en);
      check("ready_z", ifz.rf_ready, exp_ready);
      check("ready_n", ifn.rf_ready, exp_ready);
      check("state_z", 64'(st_z), exp_ready ? 64'(READY) : 64'(INIT));
`ifdef FWRISC_REGFILE_PARITY_EN
      check("perr_z", ifz.rd_perr, pz);
      check("perr_n", ifn.rd_perr, pn);
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ra0 = '0;
    ra1 = '0;
    wa  = '0;
    wd  = '0;
    we  = 1'b0;
    inj = 1'b0;
    init_cnt  = 0;
    exp_ready = 1'b0;

    step();
    step();
    rst = 1'b0;

    // Reset in the middle of the clearing sequence.
    repeat (30) step();
    check("mid_init_ready", ifz.rf_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Writes during INIT must be dropped; count release edges to rf_ready.
    we = 1'b1;
    wa = 6'd63;
    wd = 32'hCAFEF00D;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      if (k == DEPTH - 1) check("init_63_edges", ifz.rf_ready, 1'b0);
    end
    check("init_64_edges", ifz.rf_ready, 1'b1);
    we = 1'b0;

    for (int a = 0; a < DEPTH; a += 2) begin
      ra0 = AW'(a);
      ra1 = AW'(a + 1);
      step();
    end
    check("init_addr63_z", ifz.rd_rdata[63:32], 32'h0);
    check("init_addr63_n", ifn.rd_rdata[63:32], 32'h0);

    // Plain write then read.
    ra0 = '0;
    ra1 = '0;
    we = 1'b1;
    wa = 6'd5;
    wd = 32'hDEADBEEF;
    step();
    we = 1'b0;
    ra0 = 6'd5;
    step();
    check("wr_rd_5", ifz.rd_rdata[31:0], 32'hDEADBEEF);

    // Same-edge bypass on two ports, neighbouring address untouched.
    we = 1'b1;
    wa = 6'd7;
    wd = 32'h11111111;
    step();
    ra0 = 6'd7;
    ra1 = 6'd7;
    wd = 32'h22222222;
    step();
    check("bypass_p0", ifz.rd_rdata[31:0], 32'h22222222);
    check("bypass_p1", ifz.rd_rdata[63:32], 32'h22222222);
    ra1 = 6'd8;
    wd = 32'h33333333;
    step();
    check("bypass_p0_again", ifz.rd_rdata[31:0], 32'h33333333);
    check("no_bypass_addr8", ifz.rd_rdata[63:32], 32'h0);

    // Entry 0 with and without the hardwired zero.
    we = 1'b1;
    wa = 6'd0;
    wd = 32'hFFFFFFFF;
    ra0 = 6'd0;
    ra1 = 6'd7;
    step();
    we = 1'b0;
    check("zero_same_z", ifz.rd_rdata[31:0], 32'h0);
    check("zero_same_n", ifn.rd_rdata[31:0], 32'hFFFFFFFF);
    step();
    check("zero_later_z", ifz.rd_rdata[31:0], 32'h0);
    check("zero_later_n", ifn.rd_rdata[31:0], 32'hFFFFFFFF);

    // Random traffic over a small address window to force collisions.
    repeat (400) begin
      ra0 = AW'($urandom_range(0, 15));
      ra1 = AW'($urandom_range(0, 15));
      wa  = AW'($urandom_range(0, 15));
      wd  = $urandom;
      we  = ($urandom_range(0, 1) == 1);
      inj = ($urandom_range(0, 3) == 0);
      step();
    end
    inj = 1'b0;
    we  = 1'b0;

    // Reset in READY must wipe previously written data.
    we = 1'b1;
    wa = 6'd3;
    wd = 32'hA5A5A5A5;
    step();
    we = 1'b0;
    ra0 = 6'd3;
    step();
    check("pre_reset_3", ifz.rd_rdata[31:0], 32'hA5A5A5A5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (DEPTH) step();
    check("reinit_ready", ifz.rf_ready, 1'b1);
    step();
    check("post_reset_3", ifz.rd_rdata[31:0], 32'h0);

`ifdef FWRISC_REGFILE_PARITY_EN
    we  = 1'b1;
    wa  = 6'd9;
    wd  = 32'h1;
    inj = 1'b1;
    ra0 = 6'd0;
    step();
    we  = 1'b0;
    inj = 1'b0;
    ra0 = 6'd9;
    step();
    check("perr_injected", ifz.rd_perr[0], 1'b1);
    we = 1'b1;
    step();
    check("perr_bypass", ifz.rd_perr[0], 1'b0);
    we = 1'b0;
    step();
    check("perr_clean", ifz.rd_perr[0], 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fwrisc_regfile_mp.md
Name: fwrisc_regfile_mp

Overview:
Parametrised multi-read-port register file for fwrisc cores, the successor of the fixed 64x32 two-read-port file.
- Generalised in data width, depth and read-port count.
- Adds registered (1-cycle) reads with write-to-read bypass, an optional hardwired-zero entry 0, and a self-clearing init sequencer after reset.
- Sits between decode (read addresses) and writeback (write port); the core stalls issue until rf_ready is high.

Parameters:
DATA_W, 32, width of each register entry in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
N_RD, 2, number of read ports (1..4)
ZERO_R0, 1, 1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register

Ports:
clock  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_raddr  in  N_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rd_rdata  out  N_RD*DATA_W  packed registered read data; port i uses bits [i*DATA_W +: DATA_W]
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_en  in  1  write strobe; write commits at the rising edge
rf_ready  out  1  high once the init sequencer has cleared every entry

Behaviour:
- Reset (sampled at a clock edge) clears the outputs and starts the sequencer:
  - rf_ready <= 0, all rd_rdata <= 0, init pointer <= 0, state <= INIT.
  - Reset asserted mid-INIT or in READY restarts INIT from pointer 0.
- State machine:
  - INIT: each cycle writes 0 to entry[ptr], then ptr++. On the cycle with ptr == DEPTH-1: entry written, state -> READY, rf_ready <= 1.
  - Result: rf_ready rises at the DEPTH-th rising edge after reset deasserts (64 edges at defaults).
  - READY: terminal state; left only by reset.
- Writes:
  - In READY, wr_en=1 writes wr_data to entry[wr_addr] at the edge.
  - With ZERO_R0=1, a write to address 0 is dropped.
  - In INIT, wr_en is ignored; the sequencer owns the write port.
- Reads:
  - Each port samples its address at edge N; rd_rdata[i] shows the data at N+1 (1-cycle latency). Ports are fully independent, and any number may read the same address.
  - Bypass: if wr_en is high in READY and wr_addr == rd_raddr[i] at the same edge, rd_rdata[i] takes wr_data (new value), not the old entry.
  - No bypass to address 0 when ZERO_R0=1; port reads 0.
  - In INIT: all rd_rdata forced to 0.
- No X propagation: every entry is defined once rf_ready=1.

Optional Feature:
FWRISC_REGFILE_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit computed from the written data.
  - Extra input wr_par_inj (1) inverts the stored parity bit on that write, for test.
  - Extra output rd_perr (N_RD) is registered alongside rd_rdata; bit i = 1 when port i reads an entry whose stored parity mismatches its data.
  - rd_perr is forced 0 for bypassed reads, for entry 0 when ZERO_R0=1, during INIT, and on reset.
- Undefined: no parity storage, no wr_par_inj or rd_perr ports, identical timing.

Decomposition:
- Package fwrisc_regfile_pkg holds:
  - State enum typedef (INIT, READY).
  - Function to compute parity.
  - Constant for the default DATA_W/ADDR_W.
- One natural sub-module, fwrisc_regfile_rdport: a single registered read port with bypass and zero logic, instantiated N_RD times in a generate loop.
- Storage array, sequencer and write logic stay in the top module.

Test Plan:
- Init latency: reset high 2 cycles then low (defaults) -> rf_ready=0 for 63 edges, 1 at the 64th edge; every address reads 0x00000000 afterward.
- Write/read: write 0xDEADBEEF to addr 5; next cycle read port 0 addr 5 -> rd_rdata[0] = 0xDEADBEEF one cycle after the address is presented.
- Bypass plus multi-port: port 0 and port 1 both address 7 (old 0x11111111) while writing 0x22222222 to 7 at the same edge -> both ports read 0x22222222; a port addressing 8 is unaffected.
- Zero register: ZERO_R0=1, write 0xFFFFFFFF to addr 0 with a same-edge read of addr 0 -> reads 0, and 0 on later reads. ZERO_R0=0 -> reads 0xFFFFFFFF.
- Reset mid-operation:
  - Assert reset at INIT ptr=30 -> rf_ready stays 0 and rises 64 edges after deassert.
  - Reset in READY after writing addr 3 -> addr 3 reads 0 after re-init.
  - wr_en during INIT writing addr 63 -> addr 63 reads 0.
- Parity (FWRISC_REGFILE_PARITY_EN): write 0x1 to addr 9 with wr_par_inj=1, then read -> rd_perr[0]=1. Write 0x1 with inj=0, then read -> rd_perr[0]=0.
